// File: rtl/unidade_de_busca_pkg.sv
// Shared ISA constants for the fetch unit and the control logic that decodes
// its outputs, plus the fetch sequencer state encoding.
package unidade_de_busca_pkg;

  // Instruction word layout: opcode[8:6], rx[5:3], ry[2:0].
  localparam int unsigned ISA_W  = 9;
  localparam int unsigned OPC_HI = 8;
  localparam int unsigned OPC_LO = 6;
  localparam int unsigned RX_HI  = 5;
  localparam int unsigned RX_LO  = 3;
  localparam int unsigned RY_HI  = 2;
  localparam int unsigned RY_LO  = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NAN = 3'b010,
    OP_OUT = 3'b100,
    OP_LDI = 3'b101,
    OP_REP = 3'b111
  } opcode_t;

  // Execution step codes seen by the control logic on counter.
  localparam logic [1:0] STEP0 = 2'b00;
  localparam logic [1:0] STEP1 = 2'b01;
  localparam logic [1:0] STEP2 = 2'b10;
  localparam logic [1:0] STEP3 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_S1,
    ST_S2,
    ST_S3,
    ST_HALT
  } state_t;

  // States in which the step counter advances.
  function automatic logic is_exec(input state_t s);
    return (s == ST_S1) || (s == ST_S2) || (s == ST_S3);
  endfunction

  // States in which an instruction is in flight.
  function automatic logic is_busy(input state_t s);
    return (s == ST_FETCH) || (s == ST_LOAD) || is_exec(s);
  endfunction

endpackage

// File: rtl/unidade_de_busca_contador_de_passos.sv
// Two-bit execution step counter; clear has priority over enable.
module contador_de_passos
  import unidade_de_busca_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [1:0] step
);

  // Step register: returns to STEP0 on clear, advances by one on enable.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step <= STEP0;
    end else if (clear) begin
      step <= STEP0;
    end else if (enable) begin
      step <= step + 2'd1;
    end
  end

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch and step sequencer: owns pc and run/halt state, reads the
// synchronous program memory and presents each instruction on iin with the
// 00->01->10->11 step sequence on counter.
module unidade_de_busca
  import unidade_de_busca_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned INSTR_W  = 9,
  parameter int unsigned PROG_LEN = 32
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] iin,
  output logic [1:0]         counter,
  output logic               busy,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc;
  logic              step_en;

  assign mem_addr = pc;

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; run is only looked at in IDLE and when leaving S3.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (run) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_LOAD;
      ST_LOAD:  next_state = ST_S1;
      ST_S1:    next_state = ST_S2;
      ST_S2:    next_state = ST_S3;
      ST_S3: begin
        if (pc == LAST_PC)  next_state = ST_HALT;
        else if (run)       next_state = ST_FETCH;
        else                next_state = ST_IDLE;
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Program counter: advances on leaving S3 unless the last instruction ran.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc <= '0;
    end else if ((state == ST_S3) && (pc != LAST_PC)) begin
      pc <= pc + 1'b1;
    end
  end

  // Registered strobes decoded from the next state so they line up with it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_rd <= 1'b0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      mem_rd <= (next_state == ST_FETCH);
      busy   <= is_busy(next_state);
      halted <= (next_state == ST_HALT);
    end
  end

  // Instruction register: captures read data only in LOAD, while counter=00.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      iin <= '0;
    end else if (state == ST_LOAD) begin
      iin <= mem_data;
    end
  end

  // Counter steps together with the state so it reads 01/10/11 in S1/S2/S3.
  assign step_en = is_exec(next_state);

  contador_de_passos u_passos (
    .clock  (clock),
    .resetn (resetn),
    .clear  (!step_en),
    .enable (step_en),
    .step   (counter)
  );

endmodule

// File: tb/tb_unidade_de_busca.sv
// Bench for unidade_de_busca: three instances (PROG_LEN 32, 3 and 1) share
// clock/reset/run; each has its own synchronous ROM model that drives random
// data whenever no read is pending.
module tb_unidade_de_busca;

  logic clock = 1'b0;
  logic resetn;
  logic run;

  logic [4:0] mem_addr_d, mem_addr_3, mem_addr_1;
  logic       mem_rd_d, mem_rd_3, mem_rd_1;
  logic [8:0] mem_data_d, mem_data_3, mem_data_1;
  logic [8:0] iin_d, iin_3, iin_1;
  logic [1:0] counter_d, counter_3, counter_1;
  logic       busy_d, busy_3, busy_1;
  logic       halted_d, halted_3, halted_1;

  int checks   = 0;
  int failures = 0;
  int fetch_d  = 0;
  int fetch_3  = 0;
  int fetch_1  = 0;

  logic [8:0] q_d[$];
  logic [8:0] q_3[$];
  logic [8:0] cap_d, cap_3;

  always #5 clock = ~clock;

  unidade_de_busca #(.ADDR_W(5), .INSTR_W(9), .PROG_LEN(32)) u_def (
    .clock(clock), .resetn(resetn), .run(run), .mem_addr(mem_addr_d),
    .mem_rd(mem_rd_d), .mem_data(mem_data_d), .iin(iin_d),
    .counter(counter_d), .busy(busy_d), .halted(halted_d));

  unidade_de_busca #(.ADDR_W(5), .INSTR_W(9), .PROG_LEN(3)) u_p3 (
    .clock(clock), .resetn(resetn), .run(run), .mem_addr(mem_addr_3),
    .mem_rd(mem_rd_3), .mem_data(mem_data_3), .iin(iin_3),
    .counter(counter_3), .busy(busy_3), .halted(halted_3));

  unidade_de_busca #(.ADDR_W(5), .INSTR_W(9), .PROG_LEN(1)) u_p1 (
    .clock(clock), .resetn(resetn), .run(run), .mem_addr(mem_addr_1),
    .mem_rd(mem_rd_1), .mem_data(mem_data_1), .iin(iin_1),
    .counter(counter_1), .busy(busy_1), .halted(halted_1));

  function automatic logic [8:0] rom_word(input int unsigned a);
    if (a == 0) return 9'h158;
    return 9'((a * 73 + 21) % 512);
  endfunction

  // Expected counter value for phase 0..4 of an instruction (FETCH..S3).
  function automatic logic [1:0] exp_step(input int unsigned ph);
    return (ph < 2) ? 2'd0 : 2'(ph - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Synchronous ROM models: data one cycle after mem_rd, noise otherwise.
  always @(posedge clock) begin
    mem_data_d <= mem_rd_d ? rom_word(mem_addr_d) : 9'($urandom);
    mem_data_3 <= mem_rd_3 ? rom_word(mem_addr_3) : 9'($urandom);
    mem_data_1 <= mem_rd_1 ? rom_word(mem_addr_1) : 9'($urandom);
  end

  always @(negedge clock) begin
    if (mem_rd_d) fetch_d++;
    if (mem_rd_3) fetch_3++;
    if (mem_rd_1) fetch_1++;
  end

  // Scoreboard for the PROG_LEN=32 instance: pop on step 01, hold after.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (counter_d == 2'b01) begin
        checks++;
        assert (q_d.size() > 0) else begin
          failures++;
          $error("FAIL sb_def_underflow observed=empty expected=entry");
        end
        if (q_d.size() > 0) begin
          cap_d = q_d.pop_front();
          chk("iin_def", 32'(iin_d), 32'(cap_d));
        end
      end else if (counter_d == 2'b10 || counter_d == 2'b11) begin
        chk("iin_def_hold", 32'(iin_d), 32'(cap_d));
      end
    end
  end

  // Scoreboard for the PROG_LEN=3 instance.
  always @(negedge clock) begin
    if (resetn === 1'b1) begin
      if (counter_3 == 2'b01) begin
        checks++;
        assert (q_3.size() > 0) else begin
          failures++;
          $error("FAIL sb_p3_underflow observed=empty expected=entry");
        end
        if (q_3.size() > 0) begin
          cap_3 = q_3.pop_front();
          chk("iin_p3", 32'(iin_3), 32'(cap_3));
        end
      end else if (counter_3 == 2'b10 || counter_3 == 2'b11) begin
        chk("iin_p3_hold", 32'(iin_3), 32'(cap_3));
      end
    end
  end

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    repeat (2) @(negedge clock);

    chk("rst_counter", 32'(counter_d), 32'd0);
    chk("rst_iin",     32'(iin_d),     32'd0);
    chk("rst_mem_rd",  32'(mem_rd_d),  32'd0);
    chk("rst_busy",    32'(busy_d),    32'd0);
    chk("rst_halted",  32'(halted_d),  32'd0);
    chk("rst_addr",    32'(mem_addr_d), 32'd0);
    chk("rst_halt_p1", 32'(halted_1),  32'd0);

    for (int unsigned i = 0; i < 5; i++) q_d.push_back(rom_word(i));
    for (int unsigned i = 0; i < 3; i++) q_3.push_back(rom_word(i));

    resetn = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_d), 32'd0);
    chk("idle_rd",   32'(mem_rd_d), 32'd0);
    run = 1'b1;

    // Back-to-back execution; run dropped in S1 of the instruction at pc=4.
    for (int unsigned cyc = 1; cyc <= 26; cyc++) begin
      tick();
      if (cyc <= 25) begin
        chk("def_counter", 32'(counter_d), 32'(exp_step((cyc - 1) % 5)));
        chk("def_rd",      32'(mem_rd_d),  32'(((cyc - 1) % 5) == 0));
        chk("def_busy",    32'(busy_d),    32'd1);
        chk("def_addr",    32'(mem_addr_d), (cyc - 1) / 5);
      end else begin
        chk("def_stop_busy", 32'(busy_d), 32'd0);
        chk("def_stop_cnt",  32'(counter_d), 32'd0);
        chk("def_stop_rd",   32'(mem_rd_d), 32'd0);
        chk("def_stop_addr", 32'(mem_addr_d), 32'd5);
        chk("def_stop_halt", 32'(halted_d), 32'd0);
      end
      if (cyc == 3) chk("first_iin", 32'(iin_d), 32'h158);
      if (cyc <= 15) begin
        chk("p3_counter", 32'(counter_3), 32'(exp_step((cyc - 1) % 5)));
        chk("p3_busy",    32'(busy_3),    32'd1);
      end else if (cyc == 16 || cyc == 26) begin
        chk("p3_halted", 32'(halted_3), 32'd1);
        chk("p3_busy0",  32'(busy_3),   32'd0);
        chk("p3_addr",   32'(mem_addr_3), 32'd2);
        chk("p3_rd0",    32'(mem_rd_3), 32'd0);
      end
      if (cyc <= 5) begin
        chk("p1_counter", 32'(counter_1), 32'(exp_step(cyc - 1)));
      end else if (cyc == 6) begin
        chk("p1_halted", 32'(halted_1), 32'd1);
        chk("p1_busy0",  32'(busy_1),   32'd0);
        chk("p1_cnt0",   32'(counter_1), 32'd0);
      end
      if (cyc == 23) run = 1'b0;
    end

    // Stay idle, then resume at pc=5.
    repeat (2) begin
      tick();
      chk("idle_hold_rd", 32'(mem_rd_d), 32'd0);
      chk("idle_hold_busy", 32'(busy_d), 32'd0);
    end
    q_d.push_back(rom_word(5));
    run = 1'b1;
    tick();
    chk("resume_rd",   32'(mem_rd_d), 32'd1);
    chk("resume_addr", 32'(mem_addr_d), 32'd5);
    tick();
    tick();
    chk("resume_s1", 32'(counter_d), 32'd1);
    tick();
    tick();
    chk("resume_s3", 32'(counter_d), 32'd3);
    // Drop run in the S3 cycle: the sampled 0 must win, no fetch follows.
    run = 1'b0;
    tick();
    chk("s3drop_rd",   32'(mem_rd_d), 32'd0);
    chk("s3drop_busy", 32'(busy_d),   32'd0);
    chk("s3drop_addr", 32'(mem_addr_d), 32'd6);
    chk("s3drop_cnt",  32'(counter_d), 32'd0);

    q_d.push_back(rom_word(6));
    run = 1'b1;
    tick();
    chk("pc6_addr", 32'(mem_addr_d), 32'd6);
    tick();
    tick();
    tick();
    chk("pc6_s2", 32'(counter_d), 32'd2);

    // Asynchronous reset in S2: outputs clear without a clock edge.
    #1 resetn = 1'b0;
    #1;
    chk("arst_cnt",    32'(counter_d), 32'd0);
    chk("arst_iin",    32'(iin_d),     32'd0);
    chk("arst_addr",   32'(mem_addr_d), 32'd0);
    chk("arst_busy",   32'(busy_d),    32'd0);
    chk("arst_halt3",  32'(halted_3),  32'd0);
    chk("arst_halt1",  32'(halted_1),  32'd0);
    chk("arst_addr3",  32'(mem_addr_3), 32'd0);
    #1 resetn = 1'b1;

    for (int unsigned i = 0; i < 4; i++) q_d.push_back(rom_word(i));
    for (int unsigned i = 0; i < 3; i++) q_3.push_back(rom_word(i));

    tick();
    chk("restart_rd",   32'(mem_rd_d), 32'd1);
    chk("restart_addr", 32'(mem_addr_d), 32'd0);
    repeat (19) tick();

    chk("end_p3_halted", 32'(halted_3), 32'd1);
    chk("end_p3_addr",   32'(mem_addr_3), 32'd2);
    chk("end_p1_halted", 32'(halted_1), 32'd1);
    chk("end_p1_rd",     32'(mem_rd_1), 32'd0);
    chk("fetches_def",   32'(fetch_d), 32'd11);
    chk("fetches_p3",    32'(fetch_3), 32'd6);
    chk("fetches_p1",    32'(fetch_1), 32'd2);
    chk("sb_def_left",   32'(q_d.size()), 32'd0);
    chk("sb_p3_left",    32'(q_3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
